// File: rtl/elapsed_timer_if.sv
// Handshake bundle between a measurement controller and the elapsed timer.
// The controller requests start/stop and acknowledges results; the timer reports them.
interface elapsed_timer_if;
    logic        start;
    logic        stop;
    logic        ready;
    logic [10:0] elapsed_ms;
    logic        valid;
    logic        overflow;
    logic        busy;

    modport master (
        output start,
        output stop,
        output ready,
        input  elapsed_ms,
        input  valid,
        input  overflow,
        input  busy
    );

    modport slave (
        input  start,
        input  stop,
        input  ready,
        output elapsed_ms,
        output valid,
        output overflow,
        output busy
    );
endinterface

// File: rtl/elapsed_timer.sv
// Millisecond stopwatch: counts clock cycles into saturating milliseconds between
// start and stop, then holds the result until the consumer accepts it.
module elapsed_timer #(
    parameter int CYCLES_PER_MS = 25000,
    parameter int MAX_MS        = 2047
) (
    input  logic           clock,
    input  logic           reset_n,
    elapsed_timer_if.slave bus
);

    localparam int          CW       = (CYCLES_PER_MS > 1) ? $clog2(CYCLES_PER_MS) : 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(CYCLES_PER_MS - 1);
    localparam logic [10:0] MS_MAX   = 11'(MAX_MS);

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        MEASURING = 2'b01,
        HOLD      = 2'b10
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic [10:0]   ms_q, ms_d;
    logic          sat_q, sat_d;
    logic [10:0]   elapsed_q, elapsed_d;
    logic          valid_q, valid_d;
    logic          overflow_q, overflow_d;
    logic          busy_q, busy_d;

    logic          tick;
    logic [CW-1:0] cycAdv;
    logic [10:0]   msAdv;
    logic          satAdv;

    // Counter advance for this edge; a stop on a tick edge must see the ticked value.
    always_comb begin
        tick   = (cyc_q == CYC_LAST);
        cycAdv = tick ? '0 : cyc_q + CW'(1);
        msAdv  = ms_q;
        satAdv = sat_q;
        if (tick) begin
            if (ms_q >= MS_MAX) begin
                msAdv  = MS_MAX;
                satAdv = 1'b1;
            end else begin
                msAdv = ms_q + 11'd1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        ms_d       = ms_q;
        sat_d      = sat_q;
        elapsed_d  = elapsed_q;
        valid_d    = valid_q;
        overflow_d = overflow_q;
        busy_d     = busy_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    cyc_d   = '0;
                    ms_d    = '0;
                    sat_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = MEASURING;
                end
            end
            MEASURING: begin
                if (bus.stop) begin
                    elapsed_d  = msAdv;
                    overflow_d = satAdv;
                    valid_d    = 1'b1;
                    busy_d     = 1'b0;
                    cyc_d      = cycAdv;
                    ms_d       = msAdv;
                    sat_d      = satAdv;
                    state_d    = HOLD;
                end else if (bus.start) begin
                    cyc_d = '0;
                    ms_d  = '0;
                    sat_d = 1'b0;
                end else begin
                    cyc_d = cycAdv;
                    ms_d  = msAdv;
                    sat_d = satAdv;
                end
            end
            HOLD: begin
                if (bus.ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cyc_q      <= '0;
            ms_q       <= '0;
            sat_q      <= 1'b0;
            elapsed_q  <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            ms_q       <= ms_d;
            sat_q      <= sat_d;
            elapsed_q  <= elapsed_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.elapsed_ms = elapsed_q;
    assign bus.valid      = valid_q;
    assign bus.overflow   = overflow_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_elapsed_timer.sv
// Randomised and directed bench for elapsed_timer; expected results come from
// elapsed edges since the last start: min(floor(k/CYCLES_PER_MS), MAX_MS).
module tb_elapsed_timer;

    localparam int CPM   = 4;
    localparam int MAXMS = 3;

    logic clock;
    logic reset_n;
    int   total;
    int   bad;

    elapsed_timer_if bus();

    elapsed_timer #(
        .CYCLES_PER_MS(CPM),
        .MAX_MS       (MAXMS)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus.slave)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Drive inputs just after a falling edge, let one rising edge sample them.
    task automatic applyStimulus(input bit s, input bit p, input bit r);
        bus.start = s;
        bus.stop  = p;
        bus.ready = r;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic runMeasure(input int stopEdge, input int restartEdge,
                              input bit startWithStop, input int holdCycles);
        int          lastStart;
        int          q;
        logic [31:0] expMs;
        logic [31:0] expOv;
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("busyAfterStart", 32'(bus.busy), 1);
        checkOutput("validMeasuring", 32'(bus.valid), 0);
        lastStart = 0;
        for (int e = 1; e < stopEdge; e++) begin
            if (e == restartEdge) begin
                applyStimulus(1'b1, 1'b0, 1'b0);
                lastStart = e;
            end else begin
                applyStimulus(1'b0, 1'b0, 1'b0);
            end
        end
        applyStimulus(startWithStop, 1'b1, 1'b0);
        q     = (stopEdge - lastStart) / CPM;
        expMs = (q > MAXMS) ? MAXMS : q;
        expOv = (q > MAXMS) ? 1 : 0;
        checkOutput("validAfterStop", 32'(bus.valid), 1);
        checkOutput("elapsedMs", 32'(bus.elapsed_ms), expMs);
        checkOutput("overflow", 32'(bus.overflow), expOv);
        checkOutput("busyAfterStop", 32'(bus.busy), 0);
        for (int h = 0; h < holdCycles; h++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
            checkOutput("holdValid", 32'(bus.valid), 1);
            checkOutput("holdElapsed", 32'(bus.elapsed_ms), expMs);
            checkOutput("holdOverflow", 32'(bus.overflow), expOv);
            checkOutput("holdBusy", 32'(bus.busy), 0);
        end
        applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
        checkOutput("validAfterReady", 32'(bus.valid), 0);
        checkOutput("busyAfterReady", 32'(bus.busy), 0);
        checkOutput("elapsedRetained", 32'(bus.elapsed_ms), expMs);
        checkOutput("overflowRetained", 32'(bus.overflow), expOv);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            checkOutput("idleValid", 32'(bus.valid), 0);
            checkOutput("idleBusy", 32'(bus.busy), 0);
        end
    endtask

    task automatic resetPulse(input string tag);
        #2 reset_n = 1'b0;
        #1;
        checkOutput({tag, "Busy"}, 32'(bus.busy), 0);
        checkOutput({tag, "Valid"}, 32'(bus.valid), 0);
        checkOutput({tag, "Elapsed"}, 32'(bus.elapsed_ms), 0);
        checkOutput({tag, "Overflow"}, 32'(bus.overflow), 0);
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1);
            checkOutput({tag, "NoValid"}, 32'(bus.valid), 0);
            checkOutput({tag, "NoBusy"}, 32'(bus.busy), 0);
        end
    endtask

    initial begin
        int stopEdge;
        int restartEdge;
        total     = 0;
        bad       = 0;
        reset_n   = 1'b0;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.ready = 1'b0;
        @(negedge clock);
        @(negedge clock);
        checkOutput("resetValid", 32'(bus.valid), 0);
        checkOutput("resetBusy", 32'(bus.busy), 0);
        checkOutput("resetElapsed", 32'(bus.elapsed_ms), 0);
        checkOutput("resetOverflow", 32'(bus.overflow), 0);
        reset_n = 1'b1;

        // Directed scenarios
        runMeasure(10, 0, 1'b0, 2);
        runMeasure(3, 0, 1'b0, 1);
        runMeasure(4, 0, 1'b0, 1);
        runMeasure(100, 0, 1'b0, 1);
        runMeasure(5, 0, 1'b0, 1);
        runMeasure(12, 0, 1'b0, 1);
        runMeasure(16, 0, 1'b0, 1);
        runMeasure(14, 6, 1'b0, 1);
        runMeasure(8, 0, 1'b1, 1);
        runMeasure(7, 0, 1'b0, 20);

        // Asynchronous reset while measuring
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b0);
        resetPulse("rstMeas");
        runMeasure(4, 0, 1'b0, 1);

        // Asynchronous reset while holding a result
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("preRstHoldValid", 32'(bus.valid), 1);
        resetPulse("rstHold");

        // Randomised measurements
        for (int n = 0; n < 25; n++) begin
            stopEdge    = $urandom_range(1, 24);
            restartEdge = ($urandom_range(0, 1) == 1 && stopEdge > 1) ? $urandom_range(1, stopEdge - 1) : 0;
            runMeasure(stopEdge, restartEdge, 1'($urandom_range(0, 1)), $urandom_range(0, 4));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/elapsed_timer.md
ELAPSED_TIMER -- requirements
Module: elapsed_timer

Interface
REQ-001 SHALL have parameter CYCLES_PER_MS, default 25000, clock cycles per millisecond tick.
REQ-002 SHALL have parameter MAX_MS, default 2047, saturation value of the millisecond count (must fit 11 bits).
REQ-003 SHALL have port clock, input, 1, single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, level-sampled request to begin or restart a measurement.
REQ-006 SHALL have port stop, input, 1, level-sampled request to end the measurement and report.
REQ-007 SHALL have port ready, input, 1, consumer acceptance of the reported result.
REQ-008 SHALL have port elapsed_ms, output, 11, whole milliseconds measured.
REQ-009 SHALL have port valid, output, 1, elapsed_ms and overflow hold a result.
REQ-010 SHALL have port overflow, output, 1, measurement reached MAX_MS and saturated.
REQ-011 SHALL have port busy, output, 1, high while in MEASURING.

Function
REQ-012 SHALL implement states IDLE, MEASURING, HOLD; reset state IDLE.
REQ-013 IDLE: start=1 at an edge SHALL clear the cycle counter, ms counter and overflow and enter MEASURING; stop and ready are ignored in IDLE.
REQ-014 MEASURING: at every edge the cycle counter SHALL increment; when it reaches CYCLES_PER_MS-1 it SHALL wrap to 0 and the ms counter SHALL increment (a "tick").
REQ-015 The ms counter SHALL saturate at MAX_MS; a tick at MAX_MS SHALL leave it at MAX_MS and set overflow.
REQ-016 MEASURING, stop=1: SHALL latch elapsed_ms = ms counter including any tick occurring on that same edge, latch overflow, assert valid, enter HOLD.
REQ-017 MEASURING, start=1 and stop=0: SHALL restart (clear counters and overflow, remain MEASURING).
REQ-018 MEASURING, start=1 and stop=1 together: stop SHALL take priority.
REQ-019 Result: with start sampled at edge 0 and stop sampled at edge k, elapsed_ms SHALL equal min(floor(k/CYCLES_PER_MS), MAX_MS).
REQ-020 HOLD: valid, elapsed_ms, overflow SHALL remain stable until ready=1 is sampled; start and stop are ignored.
REQ-021 HOLD, ready=1: valid SHALL deassert on that edge and state SHALL return to IDLE; elapsed_ms and overflow SHALL retain their last values.
REQ-022 busy SHALL be a registered output, 1 exactly while state is MEASURING.
REQ-023 Undefined state encodings SHALL return to IDLE on the next edge.

Reset
REQ-024 reset_n=0 SHALL immediately, without a clock edge, force state IDLE, elapsed_ms=0, valid=0, overflow=0, busy=0, and clear both counters.
REQ-025 Reset asserted mid-measurement or in HOLD SHALL discard the measurement; no valid pulse SHALL follow reset release.
REQ-026 After reset_n rises, the first edge SHALL already honour start.

Verification (CYCLES_PER_MS=4, MAX_MS=3 unless stated)
REQ-027 start at edge 0, stop at edge 10 -> valid=1 after edge 10, elapsed_ms=2, overflow=0, busy=0; ready at edge 13 -> valid=0, state IDLE.
REQ-028 Boundary: stop at edge 3 -> elapsed_ms=0; stop at edge 4 (tick same edge) -> elapsed_ms=1.
REQ-029 Saturation: stop at edge 100 -> elapsed_ms=3, overflow=1; next measurement with stop at edge 5 -> elapsed_ms=1, overflow=0.
REQ-030 Restart and priority: start at 0, start again at 6, stop at 14 -> elapsed_ms=2; start+stop together at edge 8 -> elapsed_ms=2 (stop wins).
REQ-031 HOLD robustness: start and stop pulsed during HOLD with ready=0 for 20 cycles -> outputs unchanged, valid stays 1.
REQ-032 Async reset: reset_n=0 between edges during MEASURING -> busy=0 before next edge; after release no valid until a new start/stop.
